// File: rtl/pwl_sin_eval.sv
// pwl_sin_eval: 3-stage piecewise-linear sine, out = sin(clip(in_, -pi, +pi)).
// Define PWL_SIN_CLIP_FLAG_EN to add the pipelined `clipped` output.
module pwl_sin_eval #(
  parameter int IN_WIDTH   = 18,
  parameter int IN_EXP     = -14,
  parameter int OUT_WIDTH  = 18,
  parameter int OUT_EXP    = -16,
  parameter int SEG_LOG2   = 9,
  parameter int FRAC_WIDTH = 16
) (
  input  logic                 emu_clk,
  input  logic                 emu_rst,
  input  logic [IN_WIDTH-1:0]  in_,
  input  logic                 in_valid,
  output logic [OUT_WIDTH-1:0] out,
  output logic                 out_valid
`ifdef PWL_SIN_CLIP_FLAG_EN
  ,
  output logic                 clipped
`endif
);

  localparam int  N      = 1 << SEG_LOG2;
  localparam int  STAGES = 3;
  localparam real PI     = 3.14159265358979323846;
  // K = 2^KE/pi lands in [2^(IN_WIDTH+1), 2^(IN_WIDTH+2)); SH rescales it back
  localparam int  KE     = IN_WIDTH + 3;
  localparam int  SH     = KE - (IN_EXP + SEG_LOG2 - 1 + FRAC_WIDTH);
  localparam int  KW     = IN_WIDTH + 3;
  localparam int  PW     = IN_WIDTH + KW;
  localparam int  SW     = SEG_LOG2 + FRAC_WIDTH;
  localparam int  DW     = OUT_WIDTH + 1;
  localparam int  MW     = OUT_WIDTH + FRAC_WIDTH + 2;
  localparam int  YW     = OUT_WIDTH + 2;
  localparam int  AW     = SEG_LOG2 + 1;

  localparam int K_INT  = $rtoi(real'(longint'(1) << KE) / PI + 0.5);
  localparam int PI_INT = $rtoi(PI * real'(longint'(1) << -IN_EXP) + 0.5);

  localparam logic signed [KW-1:0]       K_S    = KW'(K_INT);
  localparam logic signed [IN_WIDTH-1:0] PI_Q   = IN_WIDTH'(PI_INT);
  localparam logic signed [IN_WIDTH-1:0] NPI_Q  = IN_WIDTH'(-PI_INT);
  localparam logic signed [PW-1:0]       S_OFF  = PW'(longint'(1) << (SW - 1));
  localparam logic signed [MW-1:0]       HALF   = MW'(longint'(1) << (FRAC_WIDTH - 1));
  localparam logic signed [MW-1:0]       HALF_M = MW'((longint'(1) << (FRAC_WIDTH - 1)) - 1);
  localparam logic signed [YW-1:0]       Y_MAX  = YW'((longint'(1) << (OUT_WIDTH - 1)) - 1);
  localparam logic signed [YW-1:0]       Y_MIN  = YW'(-(longint'(1) << (OUT_WIDTH - 1)));

  function automatic int sin_q(int i);
    real v;
    v = $sin(PI * (2.0 * real'(i) / real'(N) - 1.0)) * real'(longint'(1) << -OUT_EXP);
    return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
  endfunction

  // Breakpoint table: segment i spans rom[i] .. rom[i+1]
  logic signed [OUT_WIDTH-1:0] rom [N+1];
  for (genvar i = 0; i <= N; i++) begin : g_rom
    localparam int YV = sin_q(i);
    assign rom[i] = OUT_WIDTH'(YV);
  end

  logic [STAGES-1:0]           vld_pipe;
  logic signed [IN_WIDTH-1:0]  x, xc;
  logic                        clip_hi, clip_lo;
  logic signed [PW-1:0]        s;
  logic [SEG_LOG2-1:0]         idx_d, idx_q;
  logic [FRAC_WIDTH-1:0]       f_d, f_q, f2_q;
  logic [AW-1:0]               a0, a1;
  logic signed [OUT_WIDTH-1:0] y0_q;
  logic signed [DW-1:0]        d_q;
  logic signed [MW-1:0]        prod_y, prod_r;
  logic signed [YW-1:0]        y_sum;
  logic signed [OUT_WIDTH-1:0] y_sat, out_q;

  // Stage 1: clip, scale to segment units, split into index and fraction
  always_comb begin
    x       = $signed(in_);
    clip_hi = x > PI_Q;
    clip_lo = x < NPI_Q;
    xc      = clip_hi ? PI_Q : (clip_lo ? NPI_Q : x);
    s       = ((PW'(xc) * PW'(K_S)) >>> SH) + S_OFF;
    idx_d   = s[SW-1:FRAC_WIDTH];
    f_d     = s[FRAC_WIDTH-1:0];
    if (s[PW-1]) begin
      idx_d = '0;
      f_d   = '0;
    end else if (|s[PW-2:SW]) begin
      idx_d = '1;
      f_d   = '1;
    end
  end

  assign a0 = {1'b0, idx_q};
  assign a1 = a0 + AW'(1);

  // Stage 3: round d*f half away from zero, add base, saturate
  always_comb begin
    prod_y = MW'(d_q) * MW'($signed({1'b0, f2_q}));
    prod_r = prod_y + (prod_y[MW-1] ? HALF_M : HALF);
    y_sum  = YW'(y0_q) + YW'(prod_r >>> FRAC_WIDTH);
    y_sat  = y_sum[OUT_WIDTH-1:0];
    if (y_sum > Y_MAX)      y_sat = Y_MAX[OUT_WIDTH-1:0];
    else if (y_sum < Y_MIN) y_sat = Y_MIN[OUT_WIDTH-1:0];
  end

  always_ff @(posedge emu_clk) begin
    if (emu_rst) begin
      vld_pipe <= '0;
      idx_q    <= '0;
      f_q      <= '0;
      y0_q     <= '0;
      d_q      <= '0;
      f2_q     <= '0;
      out_q    <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-2:0], in_valid};
      idx_q    <= idx_d;
      f_q      <= f_d;
      y0_q     <= rom[a0];
      d_q      <= DW'(rom[a1]) - DW'(rom[a0]);
      f2_q     <= f_q;
      if (vld_pipe[1]) out_q <= y_sat;
    end
  end

  assign out       = out_q;
  assign out_valid = vld_pipe[STAGES-1];

`ifdef PWL_SIN_CLIP_FLAG_EN
  logic [STAGES-1:0] clip_pipe;

  always_ff @(posedge emu_clk) begin
    if (emu_rst) clip_pipe <= '0;
    else         clip_pipe <= {clip_pipe[STAGES-2:0], clip_hi | clip_lo};
  end

  assign clipped = clip_pipe[STAGES-1];
`endif

endmodule
